// File: rtl/atax_accel_top.sv
// ATAX kernel y = A^T * (A * x) over three Avalon-MM masters (A, x read; y write).
// Optional feature macro: ATAX_CYCLE_COUNT_EN adds the cycle_count[31:0] output.
module atax_accel_top #(
  parameter int BUS_SIZE  = 64,
  parameter int BUS_BYTES = 8,
  parameter int N         = 4,
  parameter int ADDR_W    = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 coe_start_export,
  output logic                 coe_finish_export,
  output logic                 cso_avmclk_clk,
  output logic                 rso_avmrst_reset,
  output logic                 avm_arg_A_read,
  output logic                 avm_arg_A_write,
  output logic [ADDR_W-1:0]    avm_arg_A_address,
  input  logic [BUS_SIZE-1:0]  avm_arg_A_readdata,
  output logic [BUS_SIZE-1:0]  avm_arg_A_writedata,
  input  logic                 avm_arg_A_waitrequest,
  output logic [BUS_BYTES-1:0] avm_arg_A_byteenable,
  output logic                 avm_arg_x_read,
  output logic                 avm_arg_x_write,
  output logic [ADDR_W-1:0]    avm_arg_x_address,
  input  logic [BUS_SIZE-1:0]  avm_arg_x_readdata,
  output logic [BUS_SIZE-1:0]  avm_arg_x_writedata,
  input  logic                 avm_arg_x_waitrequest,
  output logic [BUS_BYTES-1:0] avm_arg_x_byteenable,
  output logic                 avm_arg_y_read,
  output logic                 avm_arg_y_write,
  output logic [ADDR_W-1:0]    avm_arg_y_address,
  input  logic [BUS_SIZE-1:0]  avm_arg_y_readdata,
  output logic [BUS_SIZE-1:0]  avm_arg_y_writedata,
  input  logic                 avm_arg_y_waitrequest,
  output logic [BUS_BYTES-1:0] avm_arg_y_byteenable
`ifdef ATAX_CYCLE_COUNT_EN
  ,
  output logic [31:0]          cycle_count
`endif
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_C = CW'(N - 1);
  localparam logic [CW-1:0] ONE_C  = CW'(1);
  localparam logic [CW-1:0] ZERO_C = {CW{1'b0}};

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD_X  = 3'd1,
    S_ROW     = 3'd2,
    S_UPD     = 3'd3,
    S_WRITE_Y = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  function automatic logic [31:0] mac32(input logic [31:0] acc, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [31:0] prod;
    prod = a * b;
    return acc + prod;
  endfunction

  function automatic logic [BUS_SIZE-1:0] sext32(input logic [31:0] v);
    return {{(BUS_SIZE-32){v[31]}}, v};
  endfunction

  state_t          state_r, state_n_s;
  logic [CW-1:0]   row_r, row_n_s;
  logic [CW-1:0]   col_r, col_n_s;
  logic [31:0]     tmp_r;
  logic [31:0]     xbuf_r   [N];
  logic [31:0]     rowbuf_r [N];
  logic [31:0]     ybuf_r   [N];
  logic [31:0]     upd_sum_s;
  logic [31:0]     ywd_s;
  logic [31:0]     a_elem_s;
  logic [31:0]     x_elem_s;
  logic [ADDR_W-1:0] a_addr_s;
  logic [ADDR_W-1:0] x_addr_s;
  logic [ADDR_W-1:0] y_addr_s;
  logic            unused_s;

  assign cso_avmclk_clk   = clk;
  assign rso_avmrst_reset = reset;

  assign avm_arg_A_write     = 1'b0;
  assign avm_arg_A_writedata = {BUS_SIZE{1'b0}};
  assign avm_arg_x_write     = 1'b0;
  assign avm_arg_x_writedata = {BUS_SIZE{1'b0}};
  assign avm_arg_y_read      = 1'b0;

  assign a_elem_s  = avm_arg_A_readdata[31:0];
  assign x_elem_s  = avm_arg_x_readdata[31:0];
  assign upd_sum_s = mac32(ybuf_r[col_r], rowbuf_r[col_r], tmp_r);
  assign unused_s  = ^{avm_arg_A_readdata, avm_arg_x_readdata, avm_arg_y_readdata};

  assign a_addr_s = (ADDR_W'(row_n_s) * ADDR_W'(N) + ADDR_W'(col_n_s)) * ADDR_W'(BUS_BYTES);
  assign x_addr_s = ADDR_W'(col_n_s) * ADDR_W'(BUS_BYTES);
  assign y_addr_s = ADDR_W'(col_n_s) * ADDR_W'(BUS_BYTES);

  // State and loop-counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= S_IDLE;
      row_r   <= ZERO_C;
      col_r   <= ZERO_C;
    end else begin
      state_r <= state_n_s;
      row_r   <= row_n_s;
      col_r   <= col_n_s;
    end
  end

  // Next-state and loop-counter logic; bus steps advance only on a completed transfer
  always_comb begin
    state_n_s = state_r;
    row_n_s   = row_r;
    col_n_s   = col_r;
    case (state_r)
      S_IDLE: begin
        row_n_s = ZERO_C;
        col_n_s = ZERO_C;
        if (coe_start_export) begin
          state_n_s = S_LOAD_X;
        end else begin
          state_n_s = S_IDLE;
        end
      end
      S_LOAD_X: begin
        if (!avm_arg_x_waitrequest) begin
          if (col_r == LAST_C) begin
            state_n_s = S_ROW;
            col_n_s   = ZERO_C;
            row_n_s   = ZERO_C;
          end else begin
            col_n_s = col_r + ONE_C;
          end
        end else begin
          col_n_s = col_r;
        end
      end
      S_ROW: begin
        if (!avm_arg_A_waitrequest) begin
          if (col_r == LAST_C) begin
            state_n_s = S_UPD;
            col_n_s   = ZERO_C;
          end else begin
            col_n_s = col_r + ONE_C;
          end
        end else begin
          col_n_s = col_r;
        end
      end
      S_UPD: begin
        if (col_r == LAST_C) begin
          col_n_s = ZERO_C;
          if (row_r == LAST_C) begin
            state_n_s = S_WRITE_Y;
          end else begin
            state_n_s = S_ROW;
            row_n_s   = row_r + ONE_C;
          end
        end else begin
          col_n_s = col_r + ONE_C;
        end
      end
      S_WRITE_Y: begin
        if (!avm_arg_y_waitrequest) begin
          if (col_r == LAST_C) begin
            state_n_s = S_DONE;
            col_n_s   = ZERO_C;
          end else begin
            col_n_s = col_r + ONE_C;
          end
        end else begin
          col_n_s = col_r;
        end
      end
      S_DONE: begin
        state_n_s = S_IDLE;
        col_n_s   = ZERO_C;
        row_n_s   = ZERO_C;
      end
      default: begin
        state_n_s = S_IDLE;
        col_n_s   = ZERO_C;
        row_n_s   = ZERO_C;
      end
    endcase
  end

  // y write data, forwarding the in-flight update when it targets the element about to be written
  always_comb begin
    if ((state_r == S_UPD) && (col_r == col_n_s)) begin
      ywd_s = upd_sum_s;
    end else begin
      ywd_s = ybuf_r[col_n_s];
    end
  end

  // Operand buffers, row accumulator and result accumulators
  always_ff @(posedge clk) begin
    if (reset) begin
      tmp_r <= 32'd0;
      for (int k = 0; k < N; k++) begin
        xbuf_r[k]   <= 32'd0;
        rowbuf_r[k] <= 32'd0;
        ybuf_r[k]   <= 32'd0;
      end
    end else begin
      case (state_r)
        S_IDLE: begin
          if (coe_start_export) begin
            tmp_r <= 32'd0;
            for (int k = 0; k < N; k++) begin
              ybuf_r[k] <= 32'd0;
            end
          end
        end
        S_LOAD_X: begin
          tmp_r <= 32'd0;
          if (!avm_arg_x_waitrequest) begin
            xbuf_r[col_r] <= x_elem_s;
          end
        end
        S_ROW: begin
          if (!avm_arg_A_waitrequest) begin
            rowbuf_r[col_r] <= a_elem_s;
            tmp_r           <= mac32(tmp_r, a_elem_s, xbuf_r[col_r]);
          end
        end
        S_UPD: begin
          ybuf_r[col_r] <= upd_sum_s;
          if (col_r == LAST_C) begin
            tmp_r <= 32'd0;
          end
        end
        default: begin
          tmp_r <= tmp_r;
        end
      endcase
    end
  end

  // Bus request and finish registers, derived from the next state so they line up with it
  always_ff @(posedge clk) begin
    if (reset) begin
      coe_finish_export    <= 1'b0;
      avm_arg_A_read       <= 1'b0;
      avm_arg_A_address    <= {ADDR_W{1'b0}};
      avm_arg_A_byteenable <= {BUS_BYTES{1'b0}};
      avm_arg_x_read       <= 1'b0;
      avm_arg_x_address    <= {ADDR_W{1'b0}};
      avm_arg_x_byteenable <= {BUS_BYTES{1'b0}};
      avm_arg_y_write      <= 1'b0;
      avm_arg_y_address    <= {ADDR_W{1'b0}};
      avm_arg_y_writedata  <= {BUS_SIZE{1'b0}};
      avm_arg_y_byteenable <= {BUS_BYTES{1'b0}};
    end else begin
      coe_finish_export    <= (state_n_s == S_DONE);
      avm_arg_A_read       <= (state_n_s == S_ROW);
      avm_arg_A_address    <= (state_n_s == S_ROW) ? a_addr_s : {ADDR_W{1'b0}};
      avm_arg_A_byteenable <= (state_n_s == S_ROW) ? {BUS_BYTES{1'b1}} : {BUS_BYTES{1'b0}};
      avm_arg_x_read       <= (state_n_s == S_LOAD_X);
      avm_arg_x_address    <= (state_n_s == S_LOAD_X) ? x_addr_s : {ADDR_W{1'b0}};
      avm_arg_x_byteenable <= (state_n_s == S_LOAD_X) ? {BUS_BYTES{1'b1}} : {BUS_BYTES{1'b0}};
      avm_arg_y_write      <= (state_n_s == S_WRITE_Y);
      avm_arg_y_address    <= (state_n_s == S_WRITE_Y) ? y_addr_s : {ADDR_W{1'b0}};
      avm_arg_y_writedata  <= (state_n_s == S_WRITE_Y) ? sext32(ywd_s) : {BUS_SIZE{1'b0}};
      avm_arg_y_byteenable <= (state_n_s == S_WRITE_Y) ? {BUS_BYTES{1'b1}} : {BUS_BYTES{1'b0}};
    end
  end

`ifdef ATAX_CYCLE_COUNT_EN
  logic [31:0] cycle_count_r;
  assign cycle_count = cycle_count_r;

  // Busy-cycle counter: cleared on an accepted start, saturating, held after finish
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_count_r <= 32'd0;
    end else if ((state_r == S_IDLE) && coe_start_export) begin
      cycle_count_r <= 32'd0;
    end else if ((state_r != S_IDLE) && (state_r != S_DONE) && (cycle_count_r != 32'hFFFF_FFFF)) begin
      cycle_count_r <= cycle_count_r + 32'd1;
    end else begin
      cycle_count_r <= cycle_count_r;
    end
  end
`endif

endmodule

// File: tb/tb_atax_accel_top.sv
// Scoreboard bench for atax_accel_top: memory slaves with random stalls, y = A^T(Ax) reference model.
`timescale 1ns/1ps
module tb_atax_accel_top;
  localparam int N = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        finish;
  logic        fwd_clk, fwd_rst;
  logic        a_read, a_write, x_read, x_write, y_read, y_write;
  logic [31:0] a_addr, x_addr, y_addr;
  logic [63:0] a_rdata, x_rdata, y_rdata, a_wdata, x_wdata, y_wdata;
  logic        a_wait, x_wait, y_wait;
  logic [7:0]  a_be, x_be, y_be;
`ifdef ATAX_CYCLE_COUNT_EN
  logic [31:0] cycle_count;
`endif

  always #5 clk = ~clk;

  atax_accel_top dut (
    .clk(clk), .reset(reset), .coe_start_export(start), .coe_finish_export(finish),
    .cso_avmclk_clk(fwd_clk), .rso_avmrst_reset(fwd_rst),
    .avm_arg_A_read(a_read), .avm_arg_A_write(a_write), .avm_arg_A_address(a_addr),
    .avm_arg_A_readdata(a_rdata), .avm_arg_A_writedata(a_wdata),
    .avm_arg_A_waitrequest(a_wait), .avm_arg_A_byteenable(a_be),
    .avm_arg_x_read(x_read), .avm_arg_x_write(x_write), .avm_arg_x_address(x_addr),
    .avm_arg_x_readdata(x_rdata), .avm_arg_x_writedata(x_wdata),
    .avm_arg_x_waitrequest(x_wait), .avm_arg_x_byteenable(x_be),
    .avm_arg_y_read(y_read), .avm_arg_y_write(y_write), .avm_arg_y_address(y_addr),
    .avm_arg_y_readdata(y_rdata), .avm_arg_y_writedata(y_wdata),
    .avm_arg_y_waitrequest(y_wait), .avm_arg_y_byteenable(y_be)
`ifdef ATAX_CYCLE_COUNT_EN
    , .cycle_count(cycle_count)
`endif
  );

  typedef struct { logic [31:0] addr; logic [63:0] data; } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  int amem [N*N];
  int xmem [N];
  int ymem [N];
  int n_checks = 0;
  int n_err = 0;
  int cyc = 0;
  int fin_cnt = 0;
  bit stall_en = 1'b0;
  logic pa_hold = 1'b0, px_hold = 1'b0, py_hold = 1'b0, pv_rst = 1'b1;
  logic [31:0] pa_addr, px_addr, py_addr;
  logic [63:0] py_data;

  function automatic logic [63:0] sx(input int v);
    return {{32{v[31]}}, v};
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Memory slaves: readdata is valid in the accepting cycle
  always_comb begin
    a_rdata = 64'd0;
    x_rdata = 64'd0;
    y_rdata = 64'd0;
    if (a_read && (a_addr[31:3] < 29'(N*N))) a_rdata = sx(amem[int'(a_addr[31:3])]);
    if (x_read && (x_addr[31:3] < 29'(N))) x_rdata = sx(xmem[int'(x_addr[31:3])]);
  end

  // Stall generation, protocol checks and scoreboard monitor for y
  always @(negedge clk) begin
    if (stall_en && !reset) begin
      a_wait = ($urandom_range(0, 2) == 0);
      x_wait = ($urandom_range(0, 2) == 0);
      y_wait = ($urandom_range(0, 2) == 0);
    end else begin
      a_wait = 1'b0;
      x_wait = 1'b0;
      y_wait = 1'b0;
    end
    if (finish) fin_cnt++;
    chk("A_byteenable", {56'd0, a_be}, a_read ? 64'hFF : 64'h0);
    chk("x_byteenable", {56'd0, x_be}, x_read ? 64'hFF : 64'h0);
    chk("y_byteenable", {56'd0, y_be}, y_write ? 64'hFF : 64'h0);
    chk("ro_wo_lines", {61'd0, a_write, x_write, y_read}, 64'd0);
    if (!reset && !pv_rst) begin
      if (pa_hold) chk("A_stall_stable", {31'd0, a_read, a_addr}, {31'd0, 1'b1, pa_addr});
      if (px_hold) chk("x_stall_stable", {31'd0, x_read, x_addr}, {31'd0, 1'b1, px_addr});
      if (py_hold) begin
        chk("y_stall_stable", {31'd0, y_write, y_addr}, {31'd0, 1'b1, py_addr});
        chk("y_stall_data", y_wdata, py_data);
      end
    end
    if (y_write && !y_wait) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL y_unexpected: write addr %h data %h with nothing expected", y_addr, y_wdata);
      end else begin
        mon_e = sb.pop_front();
        chk("y_addr", {32'd0, y_addr}, {32'd0, mon_e.addr});
        chk("y_data", y_wdata, mon_e.data);
      end
      if (y_addr[31:3] < 29'(N)) ymem[int'(y_addr[31:3])] = int'(y_wdata[31:0]);
    end
    pa_hold = a_read && a_wait;   pa_addr = a_addr;
    px_hold = x_read && x_wait;   px_addr = x_addr;
    py_hold = y_write && y_wait;  py_addr = y_addr;  py_data = y_wdata;
    pv_rst  = reset;
  end

  // Reference: tmp_i = sum_j A[i][j]*x[j], y[j] = sum_i A[i][j]*tmp_i, all mod 2^32
  task automatic push_expected();
    int tmp [N];
    int yv;
    exp_t e;
    for (int i = 0; i < N; i++) begin
      tmp[i] = 0;
      for (int j = 0; j < N; j++) tmp[i] += amem[i*N+j] * xmem[j];
    end
    for (int j = 0; j < N; j++) begin
      yv = 0;
      for (int i = 0; i < N; i++) yv += amem[i*N+j] * tmp[i];
      e.addr = 32'(j * 8);
      e.data = sx(yv);
      sb.push_back(e);
    end
  endtask

  task automatic do_run(input string name, input bit stall, input bit poke, input bit nostall_lat);
    int t0;
    int fb;
    bit got;
    push_expected();
    for (int j = 0; j < N; j++) ymem[j] = 32'hDEAD;
    @(negedge clk); #1;
    stall_en = stall;
    start = 1'b1;
    t0 = cyc;
    fb = fin_cnt;
    @(negedge clk); #1;
    start = 1'b0;
    if (poke) begin
      repeat (8) @(negedge clk);
      #1 start = 1'b1;
      @(negedge clk); #1 start = 1'b0;
    end
    got = 1'b0;
    for (int k = 0; k < 4000 && !got; k++) begin
      @(negedge clk);
      if (finish) got = 1'b1;
    end
    if (!got) begin
      n_checks++;
      n_err++;
      $display("FAIL %s_timeout: no finish within 4000 cycles, required finish", name);
    end else if (nostall_lat) begin
      chk({name, "_latency"}, 64'(cyc - t0), 64'(2*N*N + 2*N + 1));
`ifdef ATAX_CYCLE_COUNT_EN
      chk({name, "_cycle_count"}, {32'd0, cycle_count}, 64'(2*N*N + 2*N));
`endif
    end
    repeat (4) @(negedge clk);
    chk({name, "_finish_count"}, 64'(fin_cnt - fb), 64'd1);
    chk({name, "_sb_drained"}, 64'(sb.size()), 64'd0);
    stall_en = 1'b0;
    sb.delete();
  endtask

  task automatic load_identity();
    for (int i = 0; i < N*N; i++) amem[i] = ((i / N) == (i % N)) ? 1 : 0;
    for (int j = 0; j < N; j++) xmem[j] = j + 1;
  endtask

  initial begin
    bit seen;
    reset = 1'b1;
    start = 1'b0;
    for (int i = 0; i < N*N; i++) amem[i] = 0;
    for (int j = 0; j < N; j++) begin xmem[j] = 0; ymem[j] = 0; end
    repeat (3) @(negedge clk);
    chk("reset_requests", {61'd0, a_read, x_read, y_write}, 64'd0);
    chk("reset_finish", {63'd0, finish}, 64'd0);
    chk("reset_addr", {a_addr, y_addr}, 64'd0);
    chk("reset_wdata", y_wdata, 64'd0);
    chk("reset_forward", {63'd0, fwd_rst}, 64'd1);
`ifdef ATAX_CYCLE_COUNT_EN
    chk("reset_cycle_count", {32'd0, cycle_count}, 64'd0);
`endif
    #1 reset = 1'b0;

    load_identity();
    do_run("identity", 1'b0, 1'b0, 1'b1);
    for (int j = 0; j < N; j++) chk("identity_y", 64'(ymem[j]), 64'(j + 1));

    load_identity();
    do_run("identity_stall_poke", 1'b1, 1'b1, 1'b0);

    for (int i = 0; i < N*N; i++) amem[i] = 1;
    for (int j = 0; j < N; j++) xmem[j] = 1;
    do_run("all_ones", 1'b0, 1'b0, 1'b1);
    for (int j = 0; j < N; j++) chk("all_ones_y", 64'(ymem[j]), 64'd16);

    for (int i = 0; i < N*N; i++) amem[i] = (i / N) + 1;
    xmem[0] = 1; xmem[1] = -1; xmem[2] = 2; xmem[3] = -2;
    do_run("zero_tmp", 1'b0, 1'b1, 1'b1);

    for (int i = 0; i < N*N; i++) amem[i] = -1;
    for (int j = 0; j < N; j++) xmem[j] = -5;
    do_run("neg_sext", 1'b1, 1'b0, 1'b0);
    chk("neg_sext_y0", 64'(ymem[0]), 64'(-80));

    for (int i = 0; i < N*N; i++) amem[i] = 0;
    amem[0] = 32'h7FFF_FFFF;
    for (int j = 0; j < N; j++) xmem[j] = 0;
    xmem[0] = 2;
    do_run("wrap", 1'b0, 1'b0, 1'b1);

    // Reset while the A port is being read
    load_identity();
    @(negedge clk); #1 start = 1'b1;
    @(negedge clk); #1 start = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge clk);
      if (a_read) seen = 1'b1;
    end
    chk("row_reached", {63'd0, seen}, 64'd1);
    repeat (3) @(negedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("midrun_reset_requests", {61'd0, a_read, x_read, y_write}, 64'd0);
    chk("midrun_reset_finish", {63'd0, finish}, 64'd0);
    #1 reset = 1'b0;
    sb.delete();
    load_identity();
    do_run("after_reset", 1'b0, 1'b0, 1'b1);

    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < N*N; i++) amem[i] = int'($urandom);
      for (int j = 0; j < N; j++) xmem[j] = (r == 4) ? int'($urandom_range(0, 200)) - 100 : int'($urandom);
      do_run("random", (r != 4), 1'b0, (r == 4));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end
endmodule
